// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: scalar or LANES-beat vector load/store over a
// req/ack port, stalling upstream while the access is in flight.
module memory_access_stage #(
    parameter int ADDR_W = 32,
    parameter int LANE_W = 32,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic                    VF_in,
    input  logic                    RegWrite,
    input  logic [3:0]              dest_in,
    input  logic [ADDR_W-1:0]       ALURES,
    input  logic [LANES*LANE_W-1:0] ALURES1,
    input  logic [LANES*LANE_W-1:0] R3_V3_2,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    wb_valid,
    output logic                    wb_RegWrite,
    output logic                    wb_VF,
    output logic [3:0]              wb_dest,
    output logic [LANES*LANE_W-1:0] wb_res
);
    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                        state;
    logic [BEAT_W-1:0]             beat;
    logic                          is_vec, is_st, op_rw;
    logic [3:0]                    op_dest;
    logic [ADDR_W-1:0]             base;
    logic [LANES-1:0][LANE_W-1:0]  st_data, ld_data, ld_next;

    logic mem_op, in_access, last_beat, finish;

    assign mem_op    = MemRead | MemWrite;
    assign in_access = (state == ACCESS);
    assign last_beat = is_vec ? (beat == BEAT_W'(LANES-1)) : (beat == '0);
    assign finish    = in_access && mem_ack && last_beat;

    // Load lanes as they will look once the current beat's data is captured.
    always_comb begin
        ld_next       = ld_data;
        ld_next[beat] = mem_rdata;
    end

    // Port outputs come straight from registered state so an async reset
    // drops the request immediately.
    assign mem_req   = in_access;
    assign mem_we    = in_access & is_st;
    assign mem_addr  = in_access ? ((base & ~ADDR_W'(3)) + (ADDR_W'(beat) << 2)) : '0;
    assign mem_wdata = in_access ? st_data[beat] : '0;
    assign stall     = (!in_access && in_valid && mem_op) || (in_access && !finish);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            is_vec      <= 1'b0;
            is_st       <= 1'b0;
            op_rw       <= 1'b0;
            op_dest     <= '0;
            base        <= '0;
            st_data     <= '0;
            ld_data     <= '0;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_VF       <= 1'b0;
            wb_dest     <= '0;
            wb_res      <= '0;
        end else begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (mem_op) begin
                        state   <= ACCESS;
                        beat    <= '0;
                        is_vec  <= VF_in;
                        is_st   <= MemWrite & ~MemRead;
                        op_rw   <= RegWrite;
                        op_dest <= dest_in;
                        base    <= ALURES;
                        st_data <= R3_V3_2;
                        ld_data <= '0;
                    end else begin
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= RegWrite;
                        wb_VF       <= VF_in;
                        wb_dest     <= dest_in;
                        wb_res      <= ALURES1;
                    end
                end
                ACCESS: if (mem_ack) begin
                    ld_data <= ld_next;
                    beat    <= beat + 1'b1;
                    if (last_beat) begin
                        state       <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_RegWrite <= op_rw & ~is_st;
                        wb_VF       <= is_vec;
                        wb_dest     <= op_dest;
                        wb_res      <= is_st ? '0 : ld_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
